// File: rtl/cvxif_pkg.sv
// rtl/cvxif_pkg.sv - shared types and constants for the CV-X-IF convolution command path
package cvxif_pkg;

    localparam int CONV_ADDR_W = 32;
    localparam int CONV_DIM_W  = 16;

    // funct3 encodings of the custom convolution instructions
    localparam logic [2:0] CMD_ADDR  = 3'd0;
    localparam logic [2:0] CMD_LDI   = 3'd1;
    localparam logic [2:0] CMD_LDW   = 3'd2;
    localparam logic [2:0] CMD_RADDR = 3'd3;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_CFG     = 2'd1,
        ERR_SHAPE   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } seq_err_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RUN  = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [CONV_ADDR_W-1:0] W_addr;
        logic [CONV_ADDR_W-1:0] I_addr;
        logic [CONV_ADDR_W-1:0] R_addr;
        logic [CONV_DIM_W-1:0]  I_height;
        logic [CONV_DIM_W-1:0]  I_width;
        logic [CONV_DIM_W-1:0]  I_kernels;
        logic [CONV_DIM_W-1:0]  I_channels;
        logic [CONV_DIM_W-1:0]  W_height;
        logic [CONV_DIM_W-1:0]  W_width;
        logic [CONV_DIM_W-1:0]  W_kernels;
        logic [CONV_DIM_W-1:0]  W_channels;
        logic                   padding;
        logic                   Stride;
    } convolution;

endpackage

// File: rtl/conv_out_dim.sv
// rtl/conv_out_dim.sv - combinational output dimension and fit check for one axis
module conv_out_dim #(
    parameter int DIM_W = 16
) (
    input  logic [DIM_W-1:0] in_dim,
    input  logic [DIM_W-1:0] k_dim,
    input  logic             pad,
    input  logic             stride,
    output logic [DIM_W-1:0] out_dim,
    output logic             fits
);

    // Two extra bits so padded size and the subtraction never wrap
    logic [DIM_W+1:0] padded;
    logic [DIM_W+1:0] diff;
    logic [DIM_W+1:0] shifted;

    // Padded extent, kernel fit flag and strided output size
    always_comb begin
        padded  = {2'b00, in_dim} + (pad ? (DIM_W+2)'(2) : (DIM_W+2)'(0));
        fits    = ({2'b00, k_dim} <= padded);
        diff    = padded - {2'b00, k_dim};
        shifted = stride ? (diff >> 1) : diff;
        out_dim = DIM_W'(shifted + (DIM_W+2)'(1));
    end

endmodule

// File: rtl/conv_cmd_sequencer.sv
// rtl/conv_cmd_sequencer.sv - registers convolution commands, validates config, launches and supervises the engine
import cvxif_pkg::*;

module conv_cmd_sequencer #(
    parameter int          ADDR_W         = CONV_ADDR_W,
    parameter int          DIM_W          = CONV_DIM_W,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] rs0_i,
    input  logic [ADDR_W-1:0] rs1_i,
    input  logic              pad_i,
    input  logic              stride_i,
    output convolution        cfg_o,
    output logic [DIM_W-1:0]  out_h_o,
    output logic [DIM_W-1:0]  out_w_o,
    output logic              start_o,
    output logic              abort_o,
    input  logic              eng_done_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        err_o
);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_CALC = 2'(CALC);
    localparam logic [1:0] S_RUN  = 2'(RUN);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             addr_v;
    logic             img_v;
    logic             wgt_v;
    logic [31:0]      wd_cnt;
    logic             wd_hit;
    logic             cmd_take;
    logic [DIM_W-1:0] h_dim;
    logic [DIM_W-1:0] w_dim;
    logic             h_fits;
    logic             w_fits;
    convolution       cfg_q;

    assign cmd_ready_o = (state == S_IDLE);
    assign cmd_take    = cmd_valid_i && cmd_ready_o;
    assign busy_o      = (state == S_CALC) || (state == S_RUN);
    assign cfg_o       = cfg_q;
    assign wd_hit      = (TIMEOUT_CYCLES != 0) && (wd_cnt == 32'(TIMEOUT_CYCLES));

    conv_out_dim #(.DIM_W(DIM_W)) u_dim_h (
        .in_dim  (cfg_q.I_height),
        .k_dim   (cfg_q.W_height),
        .pad     (cfg_q.padding),
        .stride  (cfg_q.Stride),
        .out_dim (h_dim),
        .fits    (h_fits)
    );

    conv_out_dim #(.DIM_W(DIM_W)) u_dim_w (
        .in_dim  (cfg_q.I_width),
        .k_dim   (cfg_q.W_width),
        .pad     (cfg_q.padding),
        .stride  (cfg_q.Stride),
        .out_dim (w_dim),
        .fits    (w_fits)
    );

    // Validation in CALC, completion/watchdog in RUN; strobes suppressed while in reset
    always_comb begin
        state_nxt = state;
        start_o   = 1'b0;
        abort_o   = 1'b0;
        done_o    = 1'b0;
        err_o     = 2'(ERR_OK);
        case (state)
            S_IDLE: begin
                if (cmd_take && funct3_i == CMD_RADDR) begin
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                state_nxt = S_IDLE;
                done_o    = 1'b1;
                if (!(addr_v && img_v && wgt_v)) begin
                    err_o = 2'(ERR_CFG);
                end else if (cfg_q.I_channels != cfg_q.W_channels) begin
                    err_o = 2'(ERR_SHAPE);
                end else if (!(h_fits && w_fits)) begin
                    err_o = 2'(ERR_SHAPE);
                end else begin
                    done_o    = 1'b0;
                    start_o   = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (eng_done_i) begin
                    done_o    = 1'b1;
                    state_nxt = S_IDLE;
                end else if (wd_hit) begin
                    done_o    = 1'b1;
                    abort_o   = 1'b1;
                    err_o     = 2'(ERR_TIMEOUT);
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (rst_i) begin
            start_o = 1'b0;
            abort_o = 1'b0;
            done_o  = 1'b0;
            err_o   = 2'(ERR_OK);
        end
    end

    // State register and watchdog counter, cleared whenever RUN is entered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            wd_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_RUN) begin
                wd_cnt <= wd_cnt + 32'd1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    // Operand capture for accepted commands; reserved funct3 values fall through untouched
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_q  <= '0;
            addr_v <= 1'b0;
            img_v  <= 1'b0;
            wgt_v  <= 1'b0;
        end else if (cmd_take) begin
            case (funct3_i)
                CMD_ADDR: begin
                    cfg_q.W_addr <= rs0_i;
                    cfg_q.I_addr <= rs1_i;
                    addr_v       <= 1'b1;
                end
                CMD_LDI: begin
                    cfg_q.I_height   <= rs0_i[DIM_W-1:0];
                    cfg_q.I_width    <= rs0_i[2*DIM_W-1:DIM_W];
                    cfg_q.I_kernels  <= rs1_i[DIM_W-1:0];
                    cfg_q.I_channels <= rs1_i[2*DIM_W-1:DIM_W];
                    img_v            <= 1'b1;
                end
                CMD_LDW: begin
                    cfg_q.W_height   <= rs0_i[DIM_W-1:0];
                    cfg_q.W_width    <= rs0_i[2*DIM_W-1:DIM_W];
                    cfg_q.W_kernels  <= rs1_i[DIM_W-1:0];
                    cfg_q.W_channels <= rs1_i[2*DIM_W-1:DIM_W];
                    cfg_q.padding    <= pad_i;
                    cfg_q.Stride     <= stride_i;
                    wgt_v            <= 1'b1;
                end
                CMD_RADDR: begin
                    cfg_q.R_addr <= rs0_i;
                end
                default: ;
            endcase
        end
    end

    // Output dimensions latch only on a successful launch
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_h_o <= '0;
            out_w_o <= '0;
        end else if (start_o) begin
            out_h_o <= h_dim;
            out_w_o <= w_dim;
        end
    end

endmodule

// File: tb/tb_conv_cmd_sequencer.sv
// tb/tb_conv_cmd_sequencer.sv - directed self-checking bench for conv_cmd_sequencer
`timescale 1ns/1ps
module tb_conv_cmd_sequencer;
    import cvxif_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs0 = '0;
    logic [31:0] rs1 = '0;
    logic        pad = 1'b0;
    logic        stride = 1'b0;
    convolution  cfg;
    logic [15:0] out_h;
    logic [15:0] out_w;
    logic        start;
    logic        abort;
    logic        eng_done = 1'b0;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    conv_cmd_sequencer #(.ADDR_W(32), .DIM_W(16), .TIMEOUT_CYCLES(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .funct3_i    (funct3),
        .rs0_i       (rs0),
        .rs1_i       (rs1),
        .pad_i       (pad),
        .stride_i    (stride),
        .cfg_o       (cfg),
        .out_h_o     (out_h),
        .out_w_o     (out_w),
        .start_o     (start),
        .abort_o     (abort),
        .eng_done_i  (eng_done),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    task automatic send_cmd(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic p, input logic s);
        cmd_valid = 1'b1;
        funct3 = f; rs0 = a; rs1 = b; pad = p; stride = s;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL reset_ready_busy: ready=%b busy=%b, want 1 0", cmd_ready, busy);
        end
        tests++;
        if ({start, abort, done, err} !== 5'b0) begin
            fails++; $display("FAIL reset_strobes: start=%b abort=%b done=%b err=%0d, want 0", start, abort, done, err);
        end
        tests++;
        if (cfg !== '0 || out_h !== 16'd0 || out_w !== 16'd0) begin
            fails++; $display("FAIL reset_cfg: out_h=%0d out_w=%0d cfg_nonzero=%b, want 0", out_h, out_w, cfg !== '0);
        end
    endtask

    task automatic test_addr();
        send_cmd(CMD_ADDR, 32'h1000, 32'h2000, 1'b0, 1'b0);
        tests++;
        if (cfg.W_addr !== 32'h1000 || cfg.I_addr !== 32'h2000 || done !== 1'b0) begin
            fails++; $display("FAIL addr: W=%h I=%h done=%b, want 1000 2000 0", cfg.W_addr, cfg.I_addr, done);
        end
    endtask

    task automatic test_run_ok();
        send_cmd(CMD_LDI, 32'h0008_0008, 32'h0004_0001, 1'b0, 1'b0);
        send_cmd(CMD_LDW, 32'h0003_0003, 32'h0004_0002, 1'b1, 1'b0);
        send_cmd(CMD_ADDR, 32'h1000, 32'h2000, 1'b0, 1'b0);
        send_cmd(CMD_RADDR, 32'h3000, 32'h0, 1'b0, 1'b0);
        tests++;
        if (start !== 1'b1 || busy !== 1'b1 || cfg.R_addr !== 32'h3000) begin
            fails++; $display("FAIL run_start: start=%b busy=%b R=%h, want 1 1 3000", start, busy, cfg.R_addr);
        end
        @(negedge clk);
        tests++;
        if (start !== 1'b0 || out_h !== 16'd8 || out_w !== 16'd8 || done !== 1'b0) begin
            fails++; $display("FAIL run_dims: start=%b h=%0d w=%0d done=%b, want 0 8 8 0", start, out_h, out_w, done);
        end
        eng_done = 1'b1;
        #1;
        tests++;
        if (done !== 1'b1 || err !== 2'd0) begin
            fails++; $display("FAIL run_done: done=%b err=%0d, want 1 0", done, err);
        end
        @(negedge clk);
        eng_done = 1'b0;
        tests++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL run_idle: done=%b ready=%b busy=%b, want 0 1 0", done, cmd_ready, busy);
        end
    endtask

    task automatic test_stride2();
        send_cmd(CMD_LDW, 32'h0003_0003, 32'h0004_0002, 1'b0, 1'b1);
        send_cmd(CMD_RADDR, 32'h3000, 32'h0, 1'b0, 1'b0);
        tests++;
        if (start !== 1'b1) begin
            fails++; $display("FAIL stride2_start: start=%b, want 1", start);
        end
        @(negedge clk);
        tests++;
        if (out_h !== 16'd3 || out_w !== 16'd3) begin
            fails++; $display("FAIL stride2_dims: h=%0d w=%0d, want 3 3", out_h, out_w);
        end
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
    endtask

    task automatic test_missing_cfg();
        apply_reset();
        send_cmd(CMD_RADDR, 32'h3000, 32'h0, 1'b0, 1'b0);
        tests++;
        if (done !== 1'b1 || err !== 2'd1 || start !== 1'b0) begin
            fails++; $display("FAIL missing_cfg: done=%b err=%0d start=%b, want 1 1 0", done, err, start);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || start !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL missing_cfg_after: done=%b start=%b busy=%b, want 0 0 0", done, start, busy);
        end
    endtask

    task automatic test_shape();
        send_cmd(CMD_ADDR, 32'h1000, 32'h2000, 1'b0, 1'b0);
        send_cmd(CMD_LDI, 32'h0008_0008, 32'h0004_0001, 1'b0, 1'b0);
        send_cmd(CMD_LDW, 32'h0003_0003, 32'h0003_0002, 1'b0, 1'b0);
        send_cmd(CMD_RADDR, 32'h3000, 32'h0, 1'b0, 1'b0);
        tests++;
        if (done !== 1'b1 || err !== 2'd2 || start !== 1'b0) begin
            fails++; $display("FAIL shape_channels: done=%b err=%0d start=%b, want 1 2 0", done, err, start);
        end
        @(negedge clk);
        send_cmd(CMD_LDW, 32'h0003_000C, 32'h0004_0002, 1'b0, 1'b0);
        send_cmd(CMD_RADDR, 32'h3000, 32'h0, 1'b0, 1'b0);
        tests++;
        if (done !== 1'b1 || err !== 2'd2 || start !== 1'b0) begin
            fails++; $display("FAIL shape_height: done=%b err=%0d start=%b, want 1 2 0", done, err, start);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic early;
        early = 1'b0;
        send_cmd(CMD_LDW, 32'h0003_0003, 32'h0004_0002, 1'b1, 1'b0);
        send_cmd(CMD_RADDR, 32'h3000, 32'h0, 1'b0, 1'b0);
        tests++;
        if (start !== 1'b1) begin
            fails++; $display("FAIL timeout_start: start=%b, want 1", start);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (abort !== 1'b0 || done !== 1'b0) early = 1'b1;
        end
        tests++;
        if (early !== 1'b0) begin
            fails++; $display("FAIL timeout_early: early abort/done seen=%b, want 0", early);
        end
        @(negedge clk);
        tests++;
        if (abort !== 1'b1 || done !== 1'b1 || err !== 2'd3) begin
            fails++; $display("FAIL timeout_fire: abort=%b done=%b err=%0d, want 1 1 3", abort, done, err);
        end
        @(negedge clk);
        tests++;
        if (abort !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL timeout_after: abort=%b busy=%b, want 0 0", abort, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        send_cmd(CMD_RADDR, 32'h3000, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (done !== 1'b0 || abort !== 1'b0 || start !== 1'b0) begin
            fails++; $display("FAIL midrun_strobes: done=%b abort=%b start=%b, want 0 0 0", done, abort, start);
        end
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || cfg !== '0 || out_h !== 16'd0 || out_w !== 16'd0) begin
            fails++; $display("FAIL midrun_reset: ready=%b busy=%b h=%0d w=%0d, want 1 0 0 0", cmd_ready, busy, out_h, out_w);
        end
    endtask

    task automatic test_cmd_during_run();
        send_cmd(CMD_ADDR, 32'h1000, 32'h2000, 1'b0, 1'b0);
        send_cmd(CMD_LDI, 32'h0008_0008, 32'h0004_0001, 1'b0, 1'b0);
        send_cmd(CMD_LDW, 32'h0003_0003, 32'h0004_0002, 1'b0, 1'b0);
        send_cmd(CMD_RADDR, 32'h3000, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b1; funct3 = CMD_LDI; rs0 = 32'h0010_0010; rs1 = 32'h0004_0001;
        #1;
        tests++;
        if (cmd_ready !== 1'b0) begin
            fails++; $display("FAIL run_ready: ready=%b, want 0", cmd_ready);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (cfg.I_height !== 16'd8) begin
            fails++; $display("FAIL run_held: I_height=%0d, want 8", cfg.I_height);
        end
        eng_done = 1'b1;
        #1;
        tests++;
        if (done !== 1'b1 || err !== 2'd0) begin
            fails++; $display("FAIL held_done: done=%b err=%0d, want 1 0", done, err);
        end
        @(negedge clk);
        eng_done = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        tests++;
        if (cfg.I_height !== 16'd16 || cfg.I_width !== 16'd16) begin
            fails++; $display("FAIL held_accept: I_height=%0d I_width=%0d, want 16 16", cfg.I_height, cfg.I_width);
        end
    endtask

    task automatic test_overwrite_reserved();
        send_cmd(CMD_LDI, 32'h0005_0006, 32'h0002_0001, 1'b0, 1'b0);
        send_cmd(CMD_LDI, 32'h0009_000A, 32'h0007_0003, 1'b0, 1'b0);
        tests++;
        if (cfg.I_height !== 16'd10 || cfg.I_width !== 16'd9 || cfg.I_kernels !== 16'd3 || cfg.I_channels !== 16'd7) begin
            fails++; $display("FAIL overwrite: h=%0d w=%0d k=%0d c=%0d, want 10 9 3 7",
                              cfg.I_height, cfg.I_width, cfg.I_kernels, cfg.I_channels);
        end
        send_cmd(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        tests++;
        if (cfg.I_height !== 16'd10 || cfg.W_addr !== 32'h1000 || busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL reserved: I_height=%0d W_addr=%h busy=%b done=%b, want 10 1000 0 0",
                              cfg.I_height, cfg.W_addr, busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_addr();
        test_run_ok();
        test_stride2();
        test_missing_cfg();
        test_shape();
        test_timeout();
        test_reset_mid_run();
        test_cmd_during_run();
        test_overwrite_reserved();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
